// File: rtl/calc_pkg.sv
// Shared types and default constants for the calculator front panel:
// debounce FSM state encoding and clock/tick defaults.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int CLK_HZ                = 100_000_000;
  localparam int DEBOUNCE_TICK_DIV     = 250_000;  // 2.5 ms at CLK_HZ
  localparam int DEBOUNCE_STABLE_CNT   = 4;
  localparam int DEBOUNCE_REPEAT_DELAY = 200;
  localparam int DEBOUNCE_REPEAT_RATE  = 40;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV clkin cycles, used as a
// clock enable by slow-rate logic (debouncer, display refresh).
module tick_gen #(
  parameter int DIV = 250_000
) (
  input  logic clkin,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/button_debouncer.sv
// Multi-button debouncer with level and press/release strobes, all in clkin.
// Optional auto-repeat of btn_press when BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined.
module button_debouncer
  import calc_pkg::*;
#(
  parameter int NUM_BTN      = 5,
  parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
  parameter int STABLE_CNT   = DEBOUNCE_STABLE_CNT,
  parameter int REPEAT_DELAY = DEBOUNCE_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEBOUNCE_REPEAT_RATE
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               sample_tick
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  if (TICK_DIV < 2 || STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("button_debouncer: illegal parameter value");
  end

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clkin (clkin),
    .reset (reset),
    .tick  (sample_tick)
  );

  // Two-flop synchronizer for the asynchronous pins.
  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync;

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    db_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             press_next, release_next, level_next;
    logic             repeat_strobe;
    logic             level_q, press_q, release_q;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      press_next   = 1'b0;
      release_next = 1'b0;
      if (sample_tick) begin
        unique case (state)
          IDLE: begin
            if (sync[i]) begin
              if (STABLE_CNT == 1) begin
                state_next = PRESSED;
                press_next = 1'b1;
              end else begin
                state_next = PRESS_WAIT;
                cnt_next   = CNT_W'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (!sync[i]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_inc >= CNT_MAX) begin
              state_next = PRESSED;
              cnt_next   = '0;
              press_next = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          PRESSED: begin
            if (!sync[i]) begin
              if (STABLE_CNT == 1) begin
                state_next   = IDLE;
                release_next = 1'b1;
              end else begin
                state_next = RELEASE_WAIT;
                cnt_next   = CNT_W'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (sync[i]) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt_inc >= CNT_MAX) begin
              state_next   = IDLE;
              cnt_next     = '0;
              release_next = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end
    end

    assign level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);

    always_ff @(posedge clkin) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        level_q   <= level_next;
        press_q   <= press_next | repeat_strobe;
        release_q <= release_next;
      end
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int HOLD_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold, hold_next, hold_inc;
    logic              repeating, repeating_next;

    assign hold_inc = hold + 1'b1;

    // Counts only ticks spent in PRESSED; RELEASE_WAIT leaves it frozen.
    always_comb begin
      hold_next      = hold;
      repeating_next = repeating;
      repeat_strobe  = 1'b0;
      if (state_next == IDLE) begin
        hold_next      = '0;
        repeating_next = 1'b0;
      end else if (sample_tick && state == PRESSED && state_next == PRESSED) begin
        if (!repeating) begin
          if (hold_inc == HOLD_W'(REPEAT_DELAY)) begin
            repeat_strobe  = 1'b1;
            repeating_next = 1'b1;
            hold_next      = '0;
          end else begin
            hold_next = hold_inc;
          end
        end else if (hold_inc == HOLD_W'(REPEAT_RATE)) begin
          repeat_strobe = 1'b1;
          hold_next     = '0;
        end else begin
          hold_next = hold_inc;
        end
      end
    end

    always_ff @(posedge clkin) begin
      if (reset) begin
        hold      <= '0;
        repeating <= 1'b0;
      end else begin
        hold      <= hold_next;
        repeating <= repeating_next;
      end
    end
`else
    assign repeat_strobe = 1'b0;
`endif

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with TICK_DIV=4, STABLE_CNT=4, NUM_BTN=5;
// expected auto-repeat behaviour follows BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module tb_button_debouncer;

  localparam int NB = 5;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic          clkin = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic          sample_tick;

  always #5 clkin = ~clkin;

  button_debouncer #(
    .NUM_BTN      (NB),
    .TICK_DIV     (4),
    .STABLE_CNT   (4),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sample_tick (sample_tick)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int press_cnt[NB]   = '{default: 0};
  int release_cnt[NB] = '{default: 0};
  int press_at[NB]    = '{default: 0};
  int ps[NB];
  int rs[NB];
  int r;
  int s;
  logic found;

  // Counts every high cycle of each strobe, so a stretched strobe counts twice.
  always @(negedge clkin) begin
    cyc++;
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i]) begin
        press_cnt[i]++;
        press_at[i] = cyc;
      end
      if (btn_release[i]) release_cnt[i]++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clkin);
    #1;
  endtask

  task automatic snap();
    ps = press_cnt;
    rs = release_cnt;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cycles(3);
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    check("rst_tick", sample_tick, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycles(1);
      check("tick_phase", sample_tick, (k % 4 == 3));
    end

    // Clean press on button 0
    snap();
    r = cyc;
    btn_raw[0] = 1'b1;
    cycles(40);
    check("clean_press_count", press_cnt[0] - ps[0], 1);
    check("clean_press_latency", (press_at[0] > r) && (press_at[0] - r <= 19), 1);
    check("clean_level", btn_level, 5'b00001);
    check("clean_other_press", (press_cnt[1] - ps[1]) + (press_cnt[2] - ps[2]) +
                               (press_cnt[3] - ps[3]) + (press_cnt[4] - ps[4]), 0);
    check("clean_release", release_cnt[0] - rs[0], 0);

    // Bounce on button 1: toggling every 3 cycles, then stable high
    snap();
    for (int t = 0; t < 10; t++) begin
      btn_raw[1] = ~btn_raw[1];
      cycles(3);
    end
    check("bounce_no_strobe", press_cnt[1] - ps[1], 0);
    check("bounce_level", btn_level, 5'b00001);
    r = cyc;
    btn_raw[1] = 1'b1;
    cycles(25);
    check("bounce_press_count", press_cnt[1] - ps[1], 1);
    check("bounce_press_latency", (press_at[1] > r) && (press_at[1] - r <= 19), 1);
    check("bounce_level_after", btn_level, 5'b00011);

    // 0-glitch of 6 cycles while PRESSED, then real release of button 0
    snap();
    btn_raw[0] = 1'b0;
    cycles(6);
    btn_raw[0] = 1'b1;
    cycles(20);
    check("glitch_no_release", release_cnt[0] - rs[0], 0);
    check("glitch_no_press", press_cnt[0] - ps[0], 0);
    check("glitch_level", btn_level, 5'b00011);
    snap();
    btn_raw[0] = 1'b0;
    cycles(30);
    check("release_count", release_cnt[0] - rs[0], 1);
    check("release_no_press", press_cnt[0] - ps[0], 0);
    check("release_level", btn_level, 5'b00010);

    // Simultaneous presses on buttons 0, 2, 4
    btn_raw = '0;
    cycles(30);
    check("idle_before_simul", btn_level, 0);
    btn_raw = 5'b10101;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycles(1);
      if (btn_press != 0) found = 1'b1;
    end
    check("simul_seen", found, 1);
    check("simul_press", btn_press, 5'b10101);
    cycles(1);
    check("simul_press_single", btn_press, 0);
    check("simul_level", btn_level, 5'b10101);

    // Reset while button 2 is in PRESS_WAIT with cnt=3
    btn_raw = '0;
    cycles(30);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycles(1);
      if (sample_tick) found = 1'b1;
    end
    check("tick_align", found, 1);
    btn_raw[2] = 1'b1;
    cycles(13);
    check("pre_reset_level", btn_level, 0);
    reset = 1'b1;
    cycles(1);
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_press", btn_press, 0);
    check("mid_rst_release", btn_release, 0);
    check("mid_rst_tick", sample_tick, 0);
    reset = 1'b0;
    snap();
    cycles(15);
    check("no_early_press", press_cnt[2] - ps[2], 0);
    check("no_early_level", btn_level, 0);
    cycles(1);
    check("fresh_press", btn_press, 5'b00100);
    check("fresh_level", btn_level, 5'b00100);

    // Hold button 2: auto-repeat strobes at +20, +28, +36 cycles when enabled
    s = press_cnt[2];
    cycles(20);
    check("repeat_first", btn_press[2], AR);
    cycles(19);
    check("repeat_count", press_cnt[2] - s, 3 * AR);

    snap();
    btn_raw = '0;
    cycles(30);
    check("final_release", release_cnt[2] - rs[2], 1);
    check("final_level", btn_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
